// File: rtl/rv32_mc.sv
`timescale 1ns/1ps
// rv32_mc: multi-cycle RV32I integer core with a variable-latency memory handshake.
// Supports the OP, OP-IMM, LUI, JAL, BRANCH, LW and SW instructions.
// An illegal or misaligned operation halts the core with a sticky trap flag.
// Ports:
//   clk, reset_n      - clock (rising edge) and synchronous active-low reset
//   in_data           - memory read data, valid with mem_ready in a WAIT state
//   mem_ready         - completion strobe for the outstanding memory request
//   out_data          - store data (valid while mem_wr is high)
//   out_mem_addr      - memory address, held until the next request
//   mem_rd, mem_wr    - one-cycle read / write request pulses
//   trap              - sticky halt flag
//   pc                - current PC (the faulting PC once trapped)
//   instret           - retired-instruction counter
module rv32_mc #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           in_data,
  input  logic                  mem_ready,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  trap,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [RETIRE_W-1:0]   instret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [5:0] {
    FETCH  = 6'b000001,
    WAIT_I = 6'b000010,
    EXEC   = 6'b000100,
    MEM    = 6'b001000,
    WAIT_D = 6'b010000,
    HALT   = 6'b100000
  } state_t;

  state_t      state;
  logic [31:0] instr;
  logic [31:0] regs [0:31];

  // Field decode from the latched instruction
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  logic is_op, is_opimm, is_lui, is_jal, is_branch, is_load, is_store;
  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // PC zero-extended to 32 bits for target arithmetic and JAL link value
  logic [31:0] pc32;
  always_comb begin
    pc32 = '0;
    pc32[ADDR_WIDTH-1:0] = pc;
  end

  logic [ADDR_WIDTH-1:0] pc_plus4;
  assign pc_plus4 = pc + ADDR_WIDTH'(4);

  // ALU shared by OP and OP-IMM; bit 30 selects SUB only for register-register ops
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  always_comb begin
    alu_b   = is_op ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_res = 32'd0;
    case (f3)
      3'b000:  alu_res = (is_op && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = instr[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic br_taken;
  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = !($signed(rs1_val) < $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = !(rs1_val < rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] ea, br_target, jal_target;
  assign ea         = rs1_val + (is_store ? imm_s : imm_i);
  assign br_target  = pc32 + imm_b;
  assign jal_target = pc32 + imm_j;

  logic legal, misaligned, bad;
  always_comb begin
    case (opcode)
      OPC_OP:     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      OPC_OPIMM:  legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                          (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OPC_LUI,
      OPC_JAL:    legal = 1'b1;
      OPC_BRANCH: legal = (f3[2:1] != 2'b01);
      OPC_LOAD,
      OPC_STORE:  legal = (f3 == 3'b010);
      default:    legal = 1'b0;
    endcase
  end
  assign misaligned = ((is_load || is_store) && ea[1:0] != 2'b00) ||
                      (is_jal && jal_target[1:0] != 2'b00) ||
                      (is_branch && br_taken && br_target[1:0] != 2'b00);
  assign bad = !legal || misaligned;

  // Register-file write port: EXEC results and load data from WAIT_D
  logic        rf_we;
  logic [31:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wd = in_data;
    if (state == EXEC) begin
      rf_we = (is_op || is_opimm || is_lui || is_jal) && !bad;
      rf_wd = is_lui ? imm_u : is_jal ? pc32 + 32'd4 : alu_res;
    end else if (state == WAIT_D) begin
      rf_we = mem_ready && is_load;
    end
    // Reset abandons a completing load, and x0 is never written
    rf_we = rf_we && reset_n && (rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rf_we) regs[rd] <= rf_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= FETCH;
      pc           <= RESET_PC[ADDR_WIDTH-1:0];
      out_mem_addr <= '0;
      out_data     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      trap         <= 1'b0;
      instret      <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      unique case (state)
        FETCH: begin
          out_mem_addr <= pc;
          mem_rd       <= 1'b1;
          state        <= WAIT_I;
        end
        WAIT_I: begin
          if (mem_ready) begin
            instr <= in_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (bad) begin
            trap  <= 1'b1;
            state <= HALT;
          end else if (is_load || is_store) begin
            state <= MEM;
          end else begin
            if (is_jal)                     pc <= jal_target[ADDR_WIDTH-1:0];
            else if (is_branch && br_taken) pc <= br_target[ADDR_WIDTH-1:0];
            else                            pc <= pc_plus4;
            instret <= instret + RETIRE_W'(1);
            state   <= FETCH;
          end
        end
        MEM: begin
          // instr and the register file are unchanged since EXEC, so ea is still valid
          out_mem_addr <= ea[ADDR_WIDTH-1:0];
          if (is_store) begin
            mem_wr   <= 1'b1;
            out_data <= rs2_val;
          end else begin
            mem_rd <= 1'b1;
          end
          state <= WAIT_D;
        end
        WAIT_D: begin
          if (mem_ready) begin
            pc      <= pc_plus4;
            instret <= instret + RETIRE_W'(1);
            state   <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mc.sv
`timescale 1ns/1ps
module tb_rv32_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        mem_ready;
  logic [31:0] out_data;
  logic [31:0] out_mem_addr;
  logic        mem_rd, mem_wr, trap;
  logic [31:0] pc;
  logic [31:0] instret;

  rv32_mc #(.ADDR_WIDTH(32), .RESET_PC(32'h100), .RETIRE_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .mem_ready(mem_ready),
    .out_data(out_data), .out_mem_addr(out_mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .trap(trap), .pc(pc), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem [0:127];
  assign in_data = tb_mem[out_mem_addr[8:2]];

  int checks = 0;
  int passed = 0;
  int data_delay = 0;

  // Observations collected while waiting for a retire
  int          wr_cnt, rd_cnt, both_cnt;
  logic [31:0] wr_addr, wr_data, rd_addr;

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Memory responder: fetches (addr >= 0x100) answer at once, data accesses after data_delay wait cycles
  initial begin
    bit busy;
    int wait_left;
    busy = 0;
    wait_left = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready) busy = 0;
      if (mem_rd || mem_wr) begin
        busy = 1;
        wait_left = (out_mem_addr < 32'h100) ? data_delay : 0;
        if (mem_wr) tb_mem[out_mem_addr[8:2]] = out_data;
      end
      if (busy && wait_left == 0) mem_ready = 1'b1;
      else begin
        mem_ready = 1'b0;
        if (busy) wait_left--;
      end
    end
  end

  task automatic wait_retire(output int cycles);
    logic [31:0] start;
    start = instret;
    cycles = 0; wr_cnt = 0; rd_cnt = 0; both_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      cycles++;
      if (mem_rd) begin rd_cnt++; rd_addr = out_mem_addr; end
      if (mem_wr) begin wr_cnt++; wr_addr = out_mem_addr; wr_data = out_data; end
      if (mem_rd && mem_wr) both_cnt++;
      if (instret !== start) return;
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (pc !== 32'h100) $display("FAIL reset_pc: got %h want %h", pc, 32'h100); else passed++;
    checks++; if (instret !== 32'd0) $display("FAIL reset_instret: got %0d want 0", instret); else passed++;
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) $display("FAIL reset_req: got rd=%b wr=%b want 0 0", mem_rd, mem_wr); else passed++;
    checks++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b want 0", trap); else passed++;
    checks++; if (out_mem_addr !== 32'd0 || out_data !== 32'd0) $display("FAIL reset_bus: got addr=%h data=%h want 0 0", out_mem_addr, out_data); else passed++;
    reset_n = 1'b1;
    @(posedge clk); #2;
    checks++; if (mem_rd !== 1'b1 || out_mem_addr !== 32'h100) $display("FAIL first_fetch: got rd=%b addr=%h want 1 00000100", mem_rd, out_mem_addr); else passed++;
    checks++; if (instret !== 32'd0) $display("FAIL instret_before_retire: got %0d want 0", instret); else passed++;
    wait_retire(cyc);
    checks++; if (cyc !== 2 || instret !== 32'd1) $display("FAIL addi1_retire: got cyc=%0d instret=%0d want 2 1", cyc, instret); else passed++;
    wait_retire(cyc);
    checks++; if (cyc !== 3 || instret !== 32'd2) $display("FAIL addi2_retire: got cyc=%0d instret=%0d want 3 2", cyc, instret); else passed++;
  endtask

  task automatic test_alu_store();
    int cyc;
    wait_retire(cyc);
    checks++; if (cyc !== 3 || instret !== 32'd3) $display("FAIL add_retire: got cyc=%0d instret=%0d want 3 3", cyc, instret); else passed++;
    wait_retire(cyc);
    checks++; if (cyc !== 5) $display("FAIL sw_cycles: got %0d want 5", cyc); else passed++;
    checks++; if (wr_cnt !== 1 || wr_addr !== 32'h40 || wr_data !== 32'd2) $display("FAIL sw_add_result: got n=%0d addr=%h data=%h want 1 00000040 00000002", wr_cnt, wr_addr, wr_data); else passed++;
    checks++; if (rd_cnt !== 1 || both_cnt !== 0) $display("FAIL sw_reads: got rd=%0d both=%0d want 1 0", rd_cnt, both_cnt); else passed++;
    checks++; if (instret !== 32'd4) $display("FAIL sw_instret: got %0d want 4", instret); else passed++;
  endtask

  task automatic test_load_shift();
    int cyc;
    tb_mem[16] = 32'h8000_0000;
    data_delay = 3;
    wait_retire(cyc);
    data_delay = 0;
    checks++; if (cyc !== 8) $display("FAIL lw_wait_cycles: got %0d want 8", cyc); else passed++;
    checks++; if (rd_cnt !== 2 || rd_addr !== 32'h40) $display("FAIL lw_read: got n=%0d addr=%h want 2 00000040", rd_cnt, rd_addr); else passed++;
    wait_retire(cyc);
    checks++; if (cyc !== 3 || instret !== 32'd6) $display("FAIL srai_retire: got cyc=%0d instret=%0d want 3 6", cyc, instret); else passed++;
    wait_retire(cyc);
    checks++; if (wr_addr !== 32'h44 || wr_data !== 32'hF800_0000) $display("FAIL srai_store: got addr=%h data=%h want 00000044 f8000000", wr_addr, wr_data); else passed++;
  endtask

  task automatic test_branches();
    int cyc;
    logic [31:0] exp_pc [6];
    exp_pc = '{32'h124, 32'h12C, 32'h134, 32'h138, 32'h13C, 32'h144};
    for (int k = 0; k < 6; k++) begin
      wait_retire(cyc);
      checks++; if (pc !== exp_pc[k] || cyc !== 3) $display("FAIL ctl_flow[%0d]: got pc=%h cyc=%0d want %h 3", k, pc, cyc, exp_pc[k]); else passed++;
    end
    wait_retire(cyc);
    checks++; if (wr_addr !== 32'h48 || wr_data !== 32'h1234_5000) $display("FAIL lui_value: got addr=%h data=%h want 00000048 12345000", wr_addr, wr_data); else passed++;
    wait_retire(cyc);
    checks++; if (wr_addr !== 32'h4C || wr_data !== 32'h140) $display("FAIL jal_link: got addr=%h data=%h want 0000004c 00000140", wr_addr, wr_data); else passed++;
    checks++; if (instret !== 32'd15) $display("FAIL instret_15: got %0d want 15", instret); else passed++;
  endtask

  task automatic test_trap_misaligned();
    int cyc;
    int reads;
    cyc = 0; reads = 0;
    for (int i = 0; i < 20 && trap !== 1'b1; i++) begin
      @(posedge clk); #2;
      cyc++;
      if (mem_rd) reads++;
    end
    checks++; if (trap !== 1'b1 || cyc !== 3) $display("FAIL lw_misalign_trap: got trap=%b cyc=%0d want 1 3", trap, cyc); else passed++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (mem_rd || mem_wr) reads++;
    end
    checks++; if (reads !== 1) $display("FAIL trap_no_data_req: got %0d requests want 1", reads); else passed++;
    checks++; if (pc !== 32'h14C || instret !== 32'd15) $display("FAIL trap_frozen: got pc=%h instret=%0d want 0000014c 15", pc, instret); else passed++;
  endtask

  task automatic test_halt_reset_opcode0();
    int cyc;
    int reads;
    reset_n = 1'b0;
    @(posedge clk); #2;
    checks++; if (trap !== 1'b0 || pc !== 32'h100 || instret !== 32'd0) $display("FAIL halt_reset: got trap=%b pc=%h instret=%0d want 0 00000100 0", trap, pc, instret); else passed++;
    tb_mem[64] = 32'h0000_0000;
    reset_n = 1'b1;
    cyc = 0; reads = 0;
    for (int i = 0; i < 20 && trap !== 1'b1; i++) begin
      @(posedge clk); #2;
      cyc++;
      if (mem_rd || mem_wr) reads++;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (mem_rd || mem_wr) reads++;
    end
    checks++; if (trap !== 1'b1 || cyc !== 3) $display("FAIL opcode0_trap: got trap=%b cyc=%0d want 1 3", trap, cyc); else passed++;
    checks++; if (pc !== 32'h100 || instret !== 32'd0 || reads !== 1) $display("FAIL opcode0_frozen: got pc=%h instret=%0d req=%0d want 00000100 0 1", pc, instret, reads); else passed++;
  endtask

  task automatic test_reset_in_wait_d();
    int cyc;
    int guard;
    tb_mem[64] = enc_i(12'h040, 5'd0, 3'b010, 5'd1, LOAD);
    data_delay = 2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    guard = 0;
    while (!(mem_rd === 1'b1 && out_mem_addr === 32'h40) && guard < 30) begin
      @(posedge clk); #2; guard++;
    end
    while (mem_ready !== 1'b1 && guard < 30) begin
      @(posedge clk); #2; guard++;
    end
    checks++; if (guard >= 30) $display("FAIL wait_d_reached: got timeout after %0d cycles want < 30", guard); else passed++;
    reset_n = 1'b0;
    @(posedge clk); #2;
    checks++; if (pc !== 32'h100 || instret !== 32'd0 || mem_rd !== 1'b0) $display("FAIL wait_d_reset: got pc=%h instret=%0d rd=%b want 00000100 0 0", pc, instret, mem_rd); else passed++;
    tb_mem[64] = enc_s(12'h050, 5'd1, 5'd0);
    data_delay = 0;
    reset_n = 1'b1;
    wait_retire(cyc);
    checks++; if (wr_addr !== 32'h50 || wr_data !== 32'd5) $display("FAIL aborted_load_no_write: got addr=%h data=%h want 00000050 00000005", wr_addr, wr_data); else passed++;
    checks++; if (cyc !== 5 || instret !== 32'd1) $display("FAIL restart_retire: got cyc=%0d instret=%0d want 5 1", cyc, instret); else passed++;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'd0;
    tb_mem[64] = enc_i(12'd5,   5'd0, 3'b000, 5'd1, OPIMM);    // 0x100 ADDI x1,x0,5
    tb_mem[65] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPIMM);    // 0x104 ADDI x2,x0,-3
    tb_mem[66] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);        // 0x108 ADD x3,x1,x2
    tb_mem[67] = enc_s(12'h040, 5'd3, 5'd0);                    // 0x10C SW x3,0x40(x0)
    tb_mem[68] = enc_i(12'h040, 5'd0, 3'b010, 5'd5, LOAD);     // 0x110 LW x5,0x40(x0)
    tb_mem[69] = enc_i(12'h404, 5'd5, 3'b101, 5'd6, OPIMM);    // 0x114 SRAI x6,x5,4
    tb_mem[70] = enc_s(12'h044, 5'd6, 5'd0);                    // 0x118 SW x6,0x44(x0)
    tb_mem[71] = enc_b(13'd8, 5'd0, 5'd1, 3'b001);              // 0x11C BNE x1,x0,+8
    tb_mem[73] = enc_b(13'd8, 5'd1, 5'd2, 3'b111);              // 0x124 BGEU x2,x1,+8
    tb_mem[75] = enc_b(13'd8, 5'd1, 5'd2, 3'b100);              // 0x12C BLT x2,x1,+8
    tb_mem[77] = enc_b(13'd8, 5'd1, 5'd2, 3'b101);              // 0x134 BGE x2,x1,+8
    tb_mem[78] = enc_u(20'h12345, 5'd7);                        // 0x138 LUI x7,0x12345
    tb_mem[79] = enc_j(21'd8, 5'd8);                            // 0x13C JAL x8,+8
    tb_mem[81] = enc_s(12'h048, 5'd7, 5'd0);                    // 0x144 SW x7,0x48(x0)
    tb_mem[82] = enc_s(12'h04C, 5'd8, 5'd0);                    // 0x148 SW x8,0x4C(x0)
    tb_mem[83] = enc_i(12'd2, 5'd0, 3'b010, 5'd1, LOAD);       // 0x14C LW x1,2(x0)

    test_reset();
    test_alu_store();
    test_load_shift();
    test_branches();
    test_trap_misaligned();
    test_halt_reset_opcode0();
    test_reset_in_wait_d();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
